// File: rtl/sprite_compositor_if.sv
// Pixel/config bus between the video timing source and sprite_compositor.
// Carries per-frame config (frame_start, player_mode, layer_en, flash_en),
// the per-pixel stream (pix_valid, DrawX/DrawY, layer_hit, layer_pix, ground_pix)
// and the composited result (Red/Green/Blue, out_valid, overlap, blink_phase).
// master: the side driving pixels and config; slave: the compositor.
interface sprite_compositor_if #(
    parameter int unsigned NUM_LAYERS = 6
);
    logic                         frame_start;
    logic [1:0]                   player_mode;
    logic [NUM_LAYERS-1:0]        layer_en;
    logic [NUM_LAYERS-1:0]        flash_en;
    logic                         pix_valid;
    logic [9:0]                   DrawX;
    logic [9:0]                   DrawY;
    logic [NUM_LAYERS-1:0]        layer_hit;
    logic [24*NUM_LAYERS-1:0]     layer_pix;
    logic [23:0]                  ground_pix;
    logic [7:0]                   Red;
    logic [7:0]                   Green;
    logic [7:0]                   Blue;
    logic                         out_valid;
    logic                         overlap;
    logic                         blink_phase;

    modport master (
        output frame_start, player_mode, layer_en, flash_en,
        output pix_valid, DrawX, DrawY, layer_hit, layer_pix, ground_pix,
        input  Red, Green, Blue, out_valid, overlap, blink_phase
    );

    modport slave (
        input  frame_start, player_mode, layer_en, flash_en,
        input  pix_valid, DrawX, DrawY, layer_hit, layer_pix, ground_pix,
        output Red, Green, Blue, out_valid, overlap, blink_phase
    );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage pipelined sprite compositor.
// Ports:
//   Clk      - pixel clock
//   Reset_n  - synchronous active-low reset
//   bus_io   - sprite_compositor_if.slave: config inputs, pixel stream inputs,
//              registered RGB/out_valid/overlap and the blink_phase state.
// Stage 1 resolves which layers are effectively visible (hit, enabled, not keyed,
// not blinked out); stage 2 picks the highest-priority colour and the overlap flag.
// Config and blink state only change on frame_start so a frame never tears.
module sprite_compositor #(
    parameter int unsigned           NUM_LAYERS   = 6,
    parameter logic [9:0]            GROUND_Y     = 10'd416,
    parameter logic [23:0]           KEY_COLOR    = 24'hFF00FF,
    parameter logic [23:0]           BG_COLOR     = 24'h000000,
    parameter logic [NUM_LAYERS-1:0] ONE_P_MASK   = {NUM_LAYERS{1'b1}} ^ NUM_LAYERS'(2),
    parameter int unsigned           FLASH_PERIOD = 8
) (
    input logic                Clk,
    input logic                Reset_n,
    sprite_compositor_if.slave bus_io
);
    localparam logic [7:0] FlashLast = 8'(FLASH_PERIOD - 1);

    // Config and blink state
    logic [NUM_LAYERS-1:0] cfg_en_q, cfg_en_d;
    logic [NUM_LAYERS-1:0] cfg_flash_q, cfg_flash_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic                  blink_q, blink_d;

    // Stage 1
    logic                      v1_q, v1_d;
    logic [NUM_LAYERS-1:0]     eff1_q, eff1_d;
    logic [24*NUM_LAYERS-1:0]  pix1_q, pix1_d;
    logic [23:0]               gpix1_q, gpix1_d;
    logic                      gnd1_q, gnd1_d;

    // Stage 2
    logic        v2_q, v2_d;
    logic [23:0] rgb2_q, rgb2_d;
    logic        ovl2_q, ovl2_d;
    logic [7:0]  hit_cnt;

    // Horizontal position does not affect compositing.
    logic unused_drawx;
    assign unused_drawx = ^bus_io.DrawX;

    always_comb begin
        cfg_en_d    = cfg_en_q;
        cfg_flash_d = cfg_flash_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (bus_io.frame_start) begin
            cfg_en_d    = bus_io.layer_en &
                          ((bus_io.player_mode == 2'b10) ? {NUM_LAYERS{1'b1}} : ONE_P_MASK);
            cfg_flash_d = bus_io.flash_en;
            if (frame_cnt_q == FlashLast) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Stage 1 uses the registered (old) config, so a frame_start pixel sees old state.
    always_comb begin
        eff1_d = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            eff1_d[i] = bus_io.layer_hit[i] & cfg_en_q[i] &
                        (bus_io.layer_pix[24*i +: 24] != KEY_COLOR) &
                        ~(cfg_flash_q[i] & blink_q);
        end
        v1_d    = bus_io.pix_valid;
        pix1_d  = bus_io.layer_pix;
        gpix1_d = bus_io.ground_pix;
        gnd1_d  = (bus_io.DrawY >= GROUND_Y);
    end

    always_comb begin
        rgb2_d  = gnd1_q ? gpix1_q : BG_COLOR;
        hit_cnt = '0;
        // Walk from lowest priority up so the lowest visible index wins.
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (eff1_q[i]) begin
                rgb2_d = pix1_q[24*i +: 24];
            end
        end
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            hit_cnt = hit_cnt + 8'(eff1_q[i]);
        end
        ovl2_d = (hit_cnt >= 8'd2);
        v2_d   = v1_q;
        if (!v1_q) begin
            rgb2_d = '0;
            ovl2_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cfg_en_q    <= ONE_P_MASK;
            cfg_flash_q <= '0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
            v1_q        <= 1'b0;
            eff1_q      <= '0;
            pix1_q      <= '0;
            gpix1_q     <= '0;
            gnd1_q      <= 1'b0;
            v2_q        <= 1'b0;
            rgb2_q      <= '0;
            ovl2_q      <= 1'b0;
        end else begin
            cfg_en_q    <= cfg_en_d;
            cfg_flash_q <= cfg_flash_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            v1_q        <= v1_d;
            eff1_q      <= eff1_d;
            pix1_q      <= pix1_d;
            gpix1_q     <= gpix1_d;
            gnd1_q      <= gnd1_d;
            v2_q        <= v2_d;
            rgb2_q      <= rgb2_d;
            ovl2_q      <= ovl2_d;
        end
    end

    assign bus_io.Red         = rgb2_q[23:16];
    assign bus_io.Green       = rgb2_q[15:8];
    assign bus_io.Blue        = rgb2_q[7:0];
    assign bus_io.out_valid   = v2_q;
    assign bus_io.overlap     = ovl2_q;
    assign bus_io.blink_phase = blink_q;
endmodule
